// File: rtl/irs3b_pkg.sv
// Shared widths, data-FSM state encoding and error bit indices for the IRS3B
// read-address responder.
package irs3b_pkg;

  localparam int IRS_ADDR_W    = 9;
  localparam int IRS_SHIFT_LEN = 10;
  localparam int IRS_DAT_W     = 12;
  localparam int IRS_SCNT_W    = 4;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_VALID  = 1'b1
  } dat_state_e;

  localparam int ERR_BAD_LEN   = 0;
  localparam int ERR_DIR_SKEW  = 1;
  localparam int ERR_OVERSHIFT = 2;

endpackage

// File: rtl/irs_sync_edge.sv
// Two-flop synchronizer plus one delay flop; rise/fall are taken between the
// second and third stages so they line up with s2/s3.
module irs_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic s2_o,
  output logic s3_o,
  output logic rise_o,
  output logic fall_o
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= d_i;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign s2_o   = r_s2;
  assign s3_o   = r_s3;
  assign rise_o = r_s2 & ~r_s3;
  assign fall_o = ~r_s2 & r_s3;

endmodule

// File: rtl/irs3b_rd_addr_responder.sv
// ASIC-side emulation of the IRS3B DO_DIR/DO_SIN/DO_SCLK read-address port.
// Optional sticky protocol checks are built when IRS3B_RESP_PROTOCOL_CHECK_EN is defined.
//   state     | meaning
//   ST_SETTLE | counting 0..DAT_SETUP_CYCLES after an address change, dat_valid_o=0
//   ST_VALID  | dat_o holds the pattern for addr_o, dat_valid_o=1
module irs3b_rd_addr_responder
  import irs3b_pkg::*;
#(
  parameter logic [1:0] STACK_NUMBER     = 2'b00,
  parameter int         DAT_SETUP_CYCLES = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  do_dir_i,
  input  logic                  do_sin_i,
  input  logic                  do_sclk_i,
  output logic [IRS_ADDR_W-1:0] addr_o,
  output logic                  addr_update_o,
  output logic [IRS_DAT_W-1:0]  dat_o,
  output logic                  dat_valid_o,
  output logic [2:0]            err_o
);

  localparam int CNT_W = (DAT_SETUP_CYCLES < 1) ? 1 : $clog2(DAT_SETUP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DAT_SETUP_CYCLES);

  logic w_dir_s2, w_dir_s3, w_dir_fall, w_dir_rise_unused, w_dir_s3_dummy_unused;
  logic w_sin_s2, w_sin_s3_unused, w_sin_rise_unused, w_sin_fall_unused;
  logic w_sclk_s2, w_sclk_s3_unused, w_sclk_rise, w_sclk_fall_unused;

  irs_sync_edge u_sync_dir (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(do_dir_i),
    .s2_o(w_dir_s2), .s3_o(w_dir_s3), .rise_o(w_dir_rise_unused), .fall_o(w_dir_fall)
  );
  irs_sync_edge u_sync_sin (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(do_sin_i),
    .s2_o(w_sin_s2), .s3_o(w_sin_s3_unused), .rise_o(w_sin_rise_unused), .fall_o(w_sin_fall_unused)
  );
  irs_sync_edge u_sync_sclk (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(do_sclk_i),
    .s2_o(w_sclk_s2), .s3_o(w_sclk_s3_unused), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall_unused)
  );
  assign w_dir_s3_dummy_unused = 1'b0;

  logic [IRS_SHIFT_LEN-1:0] r_shreg;
  logic [IRS_SCNT_W-1:0]    r_shift_cnt;
  logic [IRS_ADDR_W-1:0]    r_addr;
  logic                     r_addr_update;
  logic                     w_commit, w_incr, w_shift;
  logic [IRS_ADDR_W-1:0]    w_addr_base;

  // An SCLK edge that coincides with DIR falling is an increment on top of the commit.
  assign w_commit    = w_dir_fall && (r_shift_cnt != '0);
  assign w_incr      = w_sclk_rise && (!w_dir_s3 || w_dir_fall);
  assign w_shift     = w_sclk_rise && w_dir_s3 && !w_dir_fall;
  assign w_addr_base = w_commit ? r_shreg[IRS_SHIFT_LEN-1:1] : r_addr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_shreg       <= '0;
      r_shift_cnt   <= '0;
      r_addr        <= '0;
      r_addr_update <= 1'b0;
    end else begin
      r_addr_update <= 1'b0;
      if (w_commit || w_incr) begin
        r_addr        <= w_addr_base + IRS_ADDR_W'(w_incr);
        r_addr_update <= 1'b1;
      end
      if (w_commit) begin
        r_shift_cnt <= '0;
      end else if (w_shift) begin
        r_shreg <= {w_sin_s2, r_shreg[IRS_SHIFT_LEN-1:1]};
        if (r_shift_cnt != '1) r_shift_cnt <= r_shift_cnt + 4'd1;
      end
    end
  end

  assign addr_o        = r_addr;
  assign addr_update_o = r_addr_update;

`ifdef IRS3B_RESP_PROTOCOL_CHECK_EN
  logic [2:0] r_err;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err <= '0;
    end else begin
      if (w_commit && (r_shift_cnt != IRS_SCNT_W'(IRS_SHIFT_LEN))) r_err[ERR_BAD_LEN] <= 1'b1;
      if ((w_dir_s2 != w_dir_s3) && w_sclk_s2) r_err[ERR_DIR_SKEW] <= 1'b1;
      if (w_shift && (r_shift_cnt == IRS_SCNT_W'(IRS_SHIFT_LEN))) r_err[ERR_OVERSHIFT] <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  logic w_chk_unused;
  assign w_chk_unused = w_dir_s2 ^ w_sclk_s2;
  assign err_o = 3'b000;
`endif

  dat_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [IRS_DAT_W-1:0]  r_dat;
  logic                  w_load;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_SETTLE;
      r_cnt   <= '0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) r_dat <= {1'b0, STACK_NUMBER, r_addr};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      ST_SETTLE: begin
        if (r_addr_update) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_TC) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_VALID;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_VALID: begin
        if (r_addr_update) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SETTLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_SETTLE;
      end
    endcase
  end

  assign dat_o       = r_dat;
  assign dat_valid_o = (r_state == ST_VALID);

endmodule

// File: tb/tb_irs3b_rd_addr_responder.sv
// Randomized scoreboard bench for irs3b_rd_addr_responder; the reference model
// tracks the address with integer arithmetic and queues each expected update.
module tb_irs3b_rd_addr_responder;

  localparam logic [1:0] TB_STACK = 2'b10;
  localparam int         TB_SETUP = 3;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        do_dir_i = 1'b0;
  logic        do_sin_i = 1'b0;
  logic        do_sclk_i = 1'b0;
  logic [8:0]  addr_o;
  logic        addr_update_o;
  logic [11:0] dat_o;
  logic        dat_valid_o;
  logic [2:0]  err_o;

  irs3b_rd_addr_responder #(.STACK_NUMBER(TB_STACK), .DAT_SETUP_CYCLES(TB_SETUP)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .do_dir_i(do_dir_i), .do_sin_i(do_sin_i),
    .do_sclk_i(do_sclk_i), .addr_o(addr_o), .addr_update_o(addr_update_o),
    .dat_o(dat_o), .dat_valid_o(dat_valid_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          failures = 0;
  int          model_addr = 0;
  logic [8:0]  exp_q[$];
  int          cyc = 0;
  int          last_upd = -1;
  logic [11:0] exp_dat = 12'h000;
  logic        prev_valid = 1'b0;
  logic [8:0]  popped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: each addr_update_o pulse consumes one queued expectation.
  always @(negedge clk_i) begin
    cyc++;
    if (!rst_n_i) begin
      last_upd   = -1;
      exp_dat    = {1'b0, TB_STACK, 9'd0};
      prev_valid = 1'b0;
    end else begin
      if (addr_update_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_update: got addr 0x%0h expected no pulse at cycle %0d", addr_o, cyc);
        end else begin
          popped = exp_q.pop_front();
          chk("addr_on_update", {23'd0, addr_o}, {23'd0, popped});
          exp_dat = {1'b0, TB_STACK, popped};
        end
        last_upd = cyc;
      end
      if (last_upd >= 0 && (cyc - last_upd) >= 1 && (cyc - last_upd) <= TB_SETUP + 1)
        chk("valid_low_while_settling", {31'd0, dat_valid_o}, 32'd0);
      if (dat_valid_o && !prev_valid) begin
        if (last_upd >= 0) chk("settle_latency", cyc - last_upd, TB_SETUP + 2);
        chk("dat_pattern", {20'd0, dat_o}, {20'd0, exp_dat});
      end
      prev_valid = dat_valid_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic pulse(input logic b);
    do_sin_i  = b;
    do_sclk_i = 1'b1;
    tick($urandom_range(4, 2));
    do_sclk_i = 1'b0;
    tick($urandom_range(7, 2));
  endtask

  task automatic shift_in(input logic [15:0] bits, input int n);
    do_dir_i = 1'b1;
    tick(3);
    for (int i = 0; i < n; i++) pulse(bits[i]);
  endtask

  task automatic commit(input int e);
    model_addr = e % 512;
    exp_q.push_back(9'(model_addr));
    do_dir_i = 1'b0;
    tick(4);
  endtask

  task automatic load(input int a);
    shift_in({6'd0, 9'(a), 1'b0}, 10);
    commit(a);
  endtask

  task automatic incr(input int n);
    for (int i = 0; i < n; i++) begin
      model_addr = (model_addr + 1) % 512;
      exp_q.push_back(9'(model_addr));
      pulse(1'($urandom_range(1, 0)));
    end
  endtask

  task automatic simul(input int a);
    shift_in({6'd0, 9'(a), 1'b0}, 10);
    model_addr = (a + 1) % 512;
    exp_q.push_back(9'(model_addr));
    do_dir_i  = 1'b0;
    do_sclk_i = 1'b1;
    tick(3);
    do_sclk_i = 1'b0;
    tick(3);
  endtask

  task automatic wait_settle(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && dat_valid_o) && n < 80) begin
      tick(1);
      n++;
    end
    chk(name, {31'd0, (exp_q.size() == 0 && dat_valid_o)}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n_i   = 1'b0;
    do_dir_i  = 1'b0;
    do_sclk_i = 1'b0;
    do_sin_i  = 1'b0;
    exp_q.delete();
    tick(2);
    model_addr = 0;
    chk("rst_addr", {23'd0, addr_o}, 32'd0);
    chk("rst_update", {31'd0, addr_update_o}, 32'd0);
    chk("rst_dat", {20'd0, dat_o}, 32'd0);
    chk("rst_valid", {31'd0, dat_valid_o}, 32'd0);
    chk("rst_err", {29'd0, err_o}, 32'd0);
    rst_n_i = 1'b1;
    tick(2);
  endtask

  initial begin
    int op;
    logic [6:0] v7;
    int a;
    tick(3);
    do_reset();
    wait_settle("settle_after_reset");

    load(9'h005);
    wait_settle("settle_load_005");
    load(9'h1FE);
    wait_settle("settle_load_1fe");
    incr(3);
    wait_settle("settle_wrap_incr");
    simul(9'h050);
    wait_settle("settle_simul_050");

    for (int k = 0; k < 24; k++) begin
      op = $urandom_range(2, 0);
      case (op)
        0: load($urandom_range(511, 0));
        1: incr($urandom_range(5, 1));
        default: simul($urandom_range(511, 0));
      endcase
      if ($urandom_range(1, 0) == 1) wait_settle("settle_random");
    end
    wait_settle("settle_random_end");

    // Reset partway through a load, then a clean load must still land.
    shift_in(16'h02A5, 4);
    do_reset();
    load($urandom_range(511, 0));
    wait_settle("settle_after_midshift_reset");

    do_reset();
    v7 = 7'($urandom_range(127, 0));
    shift_in({9'd0, v7}, 7);
    commit({v7, 2'b00});
    wait_settle("settle_short_load");
`ifdef IRS3B_RESP_PROTOCOL_CHECK_EN
    chk("err_short_load", {31'd0, err_o[0]}, 32'd1);
`else
    chk("err_tied_off_short", {29'd0, err_o}, 32'd0);
`endif
    a = $urandom_range(511, 0);
    shift_in({5'd0, 9'(a), 2'b00}, 11);
    commit(a);
    wait_settle("settle_long_load");
`ifdef IRS3B_RESP_PROTOCOL_CHECK_EN
    chk("err_short_sticky", {31'd0, err_o[0]}, 32'd1);
    chk("err_overshift", {31'd0, err_o[2]}, 32'd1);
`else
    chk("err_tied_off_long", {29'd0, err_o}, 32'd0);
`endif

    tick(10);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
